// File: rtl/vga_line_scanout.sv
// VGA timing generator and line serialiser fed by a line buffer request/ready handshake.
// Latency: outputs are registered one pixel behind the counters; a line is captured on the clk edge where line_req & line_ready meet.
// Backpressure: none towards the display; a line not delivered by its first pixel is blanked and flagged as a sticky underrun.
module vga_line_scanout #(
    parameter int WIDTH      = 640,
    parameter int HEIGHT     = 480,
    parameter int PIXEL_SIZE = 8,
    parameter int H_FP       = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BP       = 48,
    parameter int V_FP       = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BP       = 33,
    localparam int LINE_W    = $clog2(HEIGHT) + 1
) (
    input  logic                        clk,
    input  logic                        resetn,
    input  logic                        pix_en,
    input  logic [WIDTH*PIXEL_SIZE-1:0] packed_line,
    input  logic                        line_ready,
    output logic                        line_req,
    output logic [LINE_W-1:0]           req_line,
    output logic [PIXEL_SIZE-1:0]       pixel,
    output logic                        hsync,
    output logic                        vsync,
    output logic                        video_on,
    output logic                        frame_start,
    output logic                        underrun
);

    localparam int H_TOTAL = WIDTH + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = HEIGHT + V_FP + V_SYNC + V_BP;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);
    localparam int PW      = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [HW-1:0] H_VIS      = HW'(WIDTH);
    localparam logic [HW-1:0] H_SYNC_BEG = HW'(WIDTH + H_FP);
    localparam logic [HW-1:0] H_SYNC_END = HW'(WIDTH + H_FP + H_SYNC);
    localparam logic [HW-1:0] H_LAST     = HW'(H_TOTAL - 1);
    localparam logic [VW-1:0] V_VIS      = VW'(HEIGHT);
    localparam logic [VW-1:0] V_SYNC_BEG = VW'(HEIGHT + V_FP);
    localparam logic [VW-1:0] V_SYNC_END = VW'(HEIGHT + V_FP + V_SYNC);
    localparam logic [VW-1:0] V_LAST     = VW'(V_TOTAL - 1);

    typedef logic [WIDTH-1:0][PIXEL_SIZE-1:0] line_t;

    logic [HW-1:0]         h_cnt;
    logic [VW-1:0]         v_cnt;
    logic [VW-1:0]         v_next;
    logic [PW-1:0]         h_idx;
    line_t                 line_reg;
    line_t                 cur_line;
    logic                  line_valid;
    logic                  accept;
    logic                  cur_valid;
    logic                  visible;
    logic                  h_wrap;
    logic                  v_wrap;
    logic                  line_start;
    logic                  in_hsync;
    logic                  in_vsync;
    logic [PIXEL_SIZE-1:0] pix_sel;

    always_comb begin
        accept     = line_req & line_ready;
        h_wrap     = (h_cnt == H_LAST);
        v_wrap     = (v_cnt == V_LAST);
        v_next     = v_wrap ? '0 : v_cnt + VW'(1);
        h_idx      = h_cnt[PW-1:0];
        visible    = (h_cnt < H_VIS) && (v_cnt < V_VIS);
        line_start = (h_cnt == '0) && (v_cnt < V_VIS);
        in_hsync   = (h_cnt >= H_SYNC_BEG) && (h_cnt < H_SYNC_END);
        in_vsync   = (v_cnt >= V_SYNC_BEG) && (v_cnt < V_SYNC_END);
        // A line arriving on the very edge of its first pixel must be shown from pixel 0.
        cur_line   = accept ? line_t'(packed_line) : line_reg;
        cur_valid  = accept | line_valid;
        pix_sel    = (visible && cur_valid) ? cur_line[h_idx] : '0;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            h_cnt       <= H_VIS;
            v_cnt       <= V_LAST;
            line_reg    <= '0;
            line_valid  <= 1'b0;
            line_req    <= 1'b0;
            req_line    <= '0;
            pixel       <= '0;
            hsync       <= 1'b1;
            vsync       <= 1'b1;
            video_on    <= 1'b0;
            frame_start <= 1'b0;
            underrun    <= 1'b0;
        end else begin
            frame_start <= 1'b0;
            if (accept) begin
                line_reg   <= line_t'(packed_line);
                line_valid <= 1'b1;
                line_req   <= 1'b0;
            end
            if (pix_en) begin
                h_cnt <= h_wrap ? '0 : h_cnt + HW'(1);
                if (h_wrap) begin
                    v_cnt <= v_next;
                end
                video_on    <= visible;
                hsync       <= ~in_hsync;
                vsync       <= ~in_vsync;
                pixel       <= pix_sel;
                frame_start <= h_wrap & v_wrap;
                if (line_start && line_req && !line_ready) begin
                    line_req   <= 1'b0;
                    line_valid <= 1'b0;
                    underrun   <= 1'b1;
                end
                // Drop the shown line once its visible span ends so an early
                // delivery of the next line during blanking is not discarded.
                if (h_cnt == H_VIS) begin
                    line_valid <= 1'b0;
                    if (v_next < V_VIS) begin
                        line_req <= 1'b1;
                        req_line <= LINE_W'(v_next);
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_vga_line_scanout.sv
// Randomised bench for vga_line_scanout on a reduced raster, checked every clk against a timeline model.
module tb_vga_line_scanout;

    localparam int W   = 16;
    localparam int H   = 8;
    localparam int PS  = 8;
    localparam int HFP = 2;
    localparam int HS  = 3;
    localparam int HBP = 4;
    localparam int VFP = 1;
    localparam int VS  = 2;
    localparam int VBP = 2;
    localparam int HT  = W + HFP + HS + HBP;
    localparam int VT  = H + VFP + VS + VBP;
    localparam int FR  = HT * VT;
    localparam int LW  = $clog2(H) + 1;
    localparam longint START = longint'((VT - 1) * HT + W);

    logic              clk = 1'b0;
    logic              resetn;
    logic              pix_en;
    logic [W*PS-1:0]   packed_line;
    logic              line_ready;
    logic              line_req;
    logic [LW-1:0]     req_line;
    logic [PS-1:0]     pixel;
    logic              hsync;
    logic              vsync;
    logic              video_on;
    logic              frame_start;
    logic              underrun;

    vga_line_scanout #(
        .WIDTH(W), .HEIGHT(H), .PIXEL_SIZE(PS),
        .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
        .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP)
    ) dut (
        .clk(clk),
        .resetn(resetn),
        .pix_en(pix_en),
        .packed_line(packed_line),
        .line_ready(line_ready),
        .line_req(line_req),
        .req_line(req_line),
        .pixel(pixel),
        .hsync(hsync),
        .vsync(vsync),
        .video_on(video_on),
        .frame_start(frame_start),
        .underrun(underrun)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: everything is derived from the absolute raster position
    // of each pix_en edge and the deadline of each outstanding request.
    longint          kidx;
    bit              req_open;
    longint          req_tgt_abs;
    int              exp_req_line;
    longint          ok_abs;
    logic [W*PS-1:0] cap;
    int              exp_pixel;
    bit              exp_hs, exp_vs, exp_von, exp_fs, exp_ur;

    // Responder state
    longint seen_tgt;
    int     wait_c;
    int     off;
    bit     withhold;
    bit     at_deadline;
    int     phase;
    int     cyc;

    task automatic check_eq(input string tag, input longint obs, input longint exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        kidx         = 0;
        req_open     = 1'b0;
        req_tgt_abs  = -1;
        exp_req_line = 0;
        ok_abs       = -1;
        cap          = '0;
        exp_pixel    = 0;
        exp_hs       = 1'b1;
        exp_vs       = 1'b1;
        exp_von      = 1'b0;
        exp_fs       = 1'b0;
        exp_ur       = 1'b0;
        seen_tgt     = -1;
    endtask

    task automatic model_edge(input bit pe, input bit rdy, input logic [W*PS-1:0] dat);
        longint pos, absl;
        int h, v;
        exp_fs = 1'b0;
        if (req_open && rdy) begin
            cap      = dat;
            ok_abs   = req_tgt_abs;
            req_open = 1'b0;
        end
        if (pe) begin
            pos  = START + kidx;
            absl = pos / HT;
            h    = int'(pos % HT);
            v    = int'(absl % VT);
            if (req_open && pos == req_tgt_abs * HT) begin
                exp_ur   = 1'b1;
                req_open = 1'b0;
            end
            exp_von   = (h < W) && (v < H);
            exp_hs    = !(h >= W + HFP && h < W + HFP + HS);
            exp_vs    = !(v >= H + VFP && v < H + VFP + VS);
            exp_pixel = (exp_von && ok_abs == absl) ? int'(cap[h*PS +: PS]) : 0;
            exp_fs    = (h == HT - 1) && (v == VT - 1);
            if (h == W && ((v + 1) % VT) < H) begin
                req_open     = 1'b1;
                req_tgt_abs  = absl + 1;
                exp_req_line = (v + 1) % VT;
            end
            kidx++;
        end
    endtask

    task automatic check_all();
        check_eq("line_req",    longint'(line_req),    longint'(req_open));
        check_eq("req_line",    longint'(req_line),    longint'(exp_req_line));
        check_eq("pixel",       longint'(pixel),       longint'(exp_pixel));
        check_eq("hsync",       longint'(hsync),       longint'(exp_hs));
        check_eq("vsync",       longint'(vsync),       longint'(exp_vs));
        check_eq("video_on",    longint'(video_on),    longint'(exp_von));
        check_eq("frame_start", longint'(frame_start), longint'(exp_fs));
        check_eq("underrun",    longint'(underrun),    longint'(exp_ur));
    endtask

    function automatic logic [W*PS-1:0] gen_line(input int o);
        logic [W*PS-1:0] r;
        for (int j = 0; j < W; j++) r[j*PS +: PS] = PS'(j + o);
        return r;
    endfunction

    // One clk: choose inputs at the falling edge, step the model, check at the next falling edge.
    task automatic cycle(input int pe_pct);
        bit pe, rdy;
        logic [W*PS-1:0] dat;
        pe = (phase == 1) ? bit'(cyc[0]) : ($urandom_range(0, 99) < pe_pct);
        cyc++;
        if (req_open && req_tgt_abs != seen_tgt) begin
            seen_tgt    = req_tgt_abs;
            withhold    = (phase == 2) && (exp_req_line == 5 || $urandom_range(0, 9) == 0);
            at_deadline = (phase == 1) ? (exp_req_line == 0 || exp_req_line == 3)
                                       : ($urandom_range(0, 5) == 0);
            wait_c      = (phase == 1) ? 10 : $urandom_range(0, 22);
            off         = (phase == 1) ? 0 : $urandom_range(0, 255);
        end
        if (req_open) begin
            if (withhold)         rdy = 1'b0;
            else if (at_deadline) rdy = pe && (START + kidx == req_tgt_abs * HT);
            else                  rdy = (wait_c == 0);
            if (wait_c > 0) wait_c--;
            dat = gen_line(off);
        end else begin
            rdy = ($urandom_range(0, 7) == 0);
            dat = {$urandom(), $urandom(), $urandom(), $urandom()};
        end
        pix_en      = pe;
        line_ready  = rdy;
        packed_line = dat;
        model_edge(pe, rdy, dat);
        @(posedge clk);
        @(negedge clk);
        check_all();
    endtask

    initial begin
        bool_dummy_init();
    end

    task automatic bool_dummy_init();
        int guard;
        resetn      = 1'b0;
        pix_en      = 1'b0;
        line_ready  = 1'b0;
        packed_line = '0;
        cyc         = 0;
        phase       = 1;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        check_all();
        resetn = 1'b1;

        // Steady pixel rate, prompt deliveries, two lines delivered exactly at their deadline.
        for (int i = 0; i < 2 * FR + 40; i++) cycle(50);

        // Random pixel rate and latency; line 5 and some others withheld.
        phase = 2;
        for (int i = 0; i < 3 * FR * 2; i++) cycle(60);

        // Walk to the middle of line 5, then drop reset asynchronously mid-cycle.
        guard = 0;
        while (((START + kidx) % FR) != 5 * HT + W / 2 && guard < 4 * FR) begin
            cycle(60);
            guard++;
        end
        check_eq("reach_line5_mid", longint'(guard < 4 * FR), 1);
        pix_en     = 1'b0;
        line_ready = 1'b0;
        #2;
        resetn = 1'b0;
        #1;
        model_reset();
        check_all();
        @(negedge clk);
        check_all();
        resetn = 1'b1;

        phase = 3;
        for (int i = 0; i < 2 * FR * 2; i++) cycle(70);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    endtask

endmodule
